// File: rtl/seg7_scan_counter_0_99.sv
// ----------------------------------------------------------------------------
// seg7_scan_counter_0_99
//
// Purpose:
//   Two-digit BCD counter (00..99) that steps up or down once every TICK_DIV
//   clocks while enabled. A free-running scanner time-multiplexes the tens
//   and ones digits onto a single 4-bit BCD bus, with a channel code for the
//   downstream 7-segment decoder seg7_0_99.
//
// Parameters:
//   TICK_DIV      clk cycles per count step   (>= 2)
//   SCAN_DIV      clk cycles per digit slot   (>= 2)
//
// Ports:
//   clk           in   1  single clock, rising edge
//   rst           in   1  synchronous, active-high reset
//   en            in   1  count enable; 0 freezes digits and tick prescaler
//   up            in   1  1 = increment, 0 = decrement
//   load          in   1  synchronous load of load_tens/load_ones
//   load_tens     in   4  BCD tens value for load (clamped to 9)
//   load_ones     in   4  BCD ones value for load (clamped to 9)
//   tens          out  4  current tens digit
//   ones          out  4  current ones digit
//   wrap          out  1  one-cycle pulse on 99->00 (up) or 00->99 (down)
//   bcd           out  4  scanned digit to the decoder
//   disp_channel  out  2  2 = tens slot, 1 = ones slot
// ----------------------------------------------------------------------------
module seg7_scan_counter_0_99 #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap,
    output logic [3:0] bcd,
    output logic [1:0] disp_channel
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_scan_cnt;
    logic          r_slot_tens;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_wrap;
    logic [3:0]    r_bcd;
    logic [1:0]    r_disp;

    logic          w_tick;
    logic [3:0]    w_step_tens;
    logic [3:0]    w_step_ones;
    logic          w_step_wrap;

    // Load values above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign w_tick = en && (r_tick_cnt == TICK_LAST);

    // Next digit pair for one count step in the selected direction.
    always_comb begin
        w_step_tens = r_tens;
        w_step_ones = r_ones;
        w_step_wrap = 1'b0;
        if (up) begin
            if (r_ones != 4'd9) begin
                w_step_ones = r_ones + 4'd1;
            end else begin
                w_step_ones = 4'd0;
                if (r_tens != 4'd9) begin
                    w_step_tens = r_tens + 4'd1;
                end else begin
                    w_step_tens = 4'd0;
                    w_step_wrap = 1'b1;
                end
            end
        end else begin
            if (r_ones != 4'd0) begin
                w_step_ones = r_ones - 4'd1;
            end else begin
                w_step_ones = 4'd9;
                if (r_tens != 4'd0) begin
                    w_step_tens = r_tens - 4'd1;
                end else begin
                    w_step_tens = 4'd9;
                    w_step_wrap = 1'b1;
                end
            end
        end
    end

    // Tick prescaler: load restarts the count period, en=0 freezes it.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Digit registers and wrap pulse. Load wins over a coincident tick and
    // that tick is simply lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_tens <= clamp9(load_tens);
            r_ones <= clamp9(load_ones);
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_tens <= w_step_tens;
            r_ones <= w_step_ones;
            r_wrap <= w_step_wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Scanner runs regardless of en/load. The slot flag flips on the last
    // count, and the registered bus outputs follow the slot one cycle
    // later, so each (channel, digit) pair is updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_slot_tens <= 1'b1;
            r_bcd       <= 4'd0;
            r_disp      <= 2'd2;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt  <= '0;
                r_slot_tens <= ~r_slot_tens;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_bcd  <= r_slot_tens ? r_tens : r_ones;
            r_disp <= r_slot_tens ? 2'd2 : 2'd1;
        end
    end

    assign tens         = r_tens;
    assign ones         = r_ones;
    assign wrap         = r_wrap;
    assign bcd          = r_bcd;
    assign disp_channel = r_disp;

endmodule

// File: tb/tb_seg7_scan_counter_0_99.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_counter_0_99
//
// Purpose:
//   Self-checking bench for seg7_scan_counter_0_99 with TICK_DIV=4 and
//   SCAN_DIV=2. A behavioural model keeps the count as a plain integer
//   0..99 and derives the expected digits, wrap pulse and scanned bus.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_seg7_scan_counter_0_99;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       wrap;
    logic [3:0] bcd;
    logic [1:0] disp_channel;

    int nChecks = 0;
    int nErrors = 0;

    int mValue = 0;
    int mTick = 0;
    int mScan = 0;
    bit mSlotTens = 1'b1;
    bit mWrap = 1'b0;
    int mBcd = 0;
    int mDisp = 2;

    seg7_scan_counter_0_99 #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .up(up),
        .load(load),
        .load_tens(load_tens),
        .load_ones(load_ones),
        .tens(tens),
        .ones(ones),
        .wrap(wrap),
        .bcd(bcd),
        .disp_channel(disp_channel)
    );

    always #5 clk = ~clk;

    function automatic int clampDigit(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    // Reference behaviour for one rising edge, using the inputs seen there.
    task automatic modelEdge();
        if (rst) begin
            mValue = 0; mTick = 0; mScan = 0; mSlotTens = 1'b1;
            mWrap = 1'b0; mBcd = 0; mDisp = 2;
        end else begin
            mDisp = mSlotTens ? 2 : 1;
            mBcd  = mSlotTens ? mValue / 10 : mValue % 10;
            if (mScan == SCAN_DIV - 1) begin
                mScan = 0;
                mSlotTens = !mSlotTens;
            end else begin
                mScan++;
            end
            mWrap = 1'b0;
            if (load) begin
                mValue = clampDigit(load_tens) * 10 + clampDigit(load_ones);
                mTick = 0;
            end else if (en) begin
                if (mTick == TICK_DIV - 1) begin
                    mTick = 0;
                    if (up) begin
                        if (mValue == 99) mWrap = 1'b1;
                        mValue = (mValue + 1) % 100;
                    end else begin
                        if (mValue == 0) mWrap = 1'b1;
                        mValue = (mValue + 99) % 100;
                    end
                end else begin
                    mTick++;
                end
            end
        end
    endtask

    function automatic logic [14:0] expVec();
        return {4'(mValue / 10), 4'(mValue % 10), mWrap, 4'(mBcd), 2'(mDisp)};
    endfunction

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic clkCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lt, input logic [3:0] lo);
        rst = r; en = e; up = u; load = l; load_tens = lt; load_ones = lo;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        clkCycle();
        clkCycle();
        nChecks++;
        if ({tens, ones, wrap, bcd, disp_channel} !== {4'd0, 4'd0, 1'b0, 4'd0, 2'd2}) begin
            nErrors++;
            $display("[TB] FAIL reset_state: got t=%0d o=%0d w=%0b b=%0d ch=%0d required 0 0 0 0 2",
                     tens, ones, wrap, bcd, disp_channel);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd7);
        clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        clkCycle();
        clkCycle();
        nChecks++;
        if ({tens, ones} !== 8'h37) begin
            nErrors++;
            $display("[TB] FAIL pre_reset_37: got %0d%0d required 37", tens, ones);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        clkCycle();
        nChecks++;
        if ({tens, ones, wrap, bcd, disp_channel} !== {4'd0, 4'd0, 1'b0, 4'd0, 2'd2}) begin
            nErrors++;
            $display("[TB] FAIL mid_count_reset: got t=%0d o=%0d w=%0b b=%0d ch=%0d required 0 0 0 0 2",
                     tens, ones, wrap, bcd, disp_channel);
        end
    endtask

    task automatic test_full_up();
        int expVal;
        int wrapCount;
        expVal = 0;
        wrapCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 1; i <= 400; i++) begin
            clkCycle();
            if (i % 4 == 0) expVal = (expVal + 1) % 100;
            nChecks++;
            if ({tens, ones, wrap} !== {4'(expVal / 10), 4'(expVal % 10), (i == 400)}) begin
                nErrors++;
                $display("[TB] FAIL full_up cycle %0d: got %0d%0d w=%0b required %0d w=%0b",
                         i, tens, ones, wrap, expVal, (i == 400));
            end
            nChecks++;
            if ({tens, ones, wrap, bcd, disp_channel} !== expVec()) begin
                nErrors++;
                $display("[TB] FAIL full_up_model cycle %0d: got %h required %h",
                         i, {tens, ones, wrap, bcd, disp_channel}, expVec());
            end
            if (wrap === 1'b1) wrapCount++;
        end
        nChecks++;
        if (wrapCount != 1) begin
            nErrors++;
            $display("[TB] FAIL full_up_wrap_count: got %0d required 1", wrapCount);
        end
    endtask

    task automatic test_carry_borrow();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9);
        clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) clkCycle();
        nChecks++;
        if ({tens, ones, wrap} !== {8'h10, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL carry: got %0d%0d w=%0b required 10 w=0", tens, ones, wrap);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) clkCycle();
        nChecks++;
        if ({tens, ones, wrap} !== {8'h99, 1'b1}) begin
            nErrors++;
            $display("[TB] FAIL borrow_wrap: got %0d%0d w=%0b required 99 w=1", tens, ones, wrap);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        clkCycle();
        nChecks++;
        if ({tens, ones, wrap} !== {8'h99, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL wrap_one_cycle: got %0d%0d w=%0b required 99 w=0", tens, ones, wrap);
        end
    endtask

    task automatic test_load_clamp();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) clkCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd3);
        clkCycle();
        nChecks++;
        if ({tens, ones, wrap} !== {8'h93, 1'b0}) begin
            nErrors++;
            $display("[TB] FAIL load_clamp: got %0d%0d w=%0b required 93 w=0", tens, ones, wrap);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            clkCycle();
            nChecks++;
            if ({tens, ones} !== ((i == 4) ? 8'h94 : 8'h93)) begin
                nErrors++;
                $display("[TB] FAIL post_load_step cycle %0d: got %0d%0d required %0s",
                         i, tens, ones, (i == 4) ? "94" : "93");
            end
        end
    endtask

    task automatic test_hold();
        int chChanges;
        logic [1:0] lastCh;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd6);
        clkCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chChanges = 0;
        lastCh = disp_channel;
        for (int i = 0; i < 40; i++) begin
            up = 1'($urandom_range(0, 1));
            clkCycle();
            nChecks++;
            if ({tens, ones, wrap} !== {8'h56, 1'b0}) begin
                nErrors++;
                $display("[TB] FAIL hold cycle %0d: got %0d%0d w=%0b required 56 w=0",
                         i, tens, ones, wrap);
            end
            if (disp_channel !== lastCh) chChanges++;
            lastCh = disp_channel;
        end
        nChecks++;
        if (chChanges < 19) begin
            nErrors++;
            $display("[TB] FAIL hold_scanning: got %0d channel changes required >= 19", chChanges);
        end
    endtask

    task automatic test_scan();
        int runLen;
        bit seenChange;
        logic [1:0] lastCh;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd7);
        clkCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) clkCycle();
        runLen = 0;
        seenChange = 1'b0;
        lastCh = disp_channel;
        for (int i = 0; i < 16; i++) begin
            clkCycle();
            nChecks++;
            if (!({disp_channel, bcd} === {2'd2, 4'd4} || {disp_channel, bcd} === {2'd1, 4'd7})) begin
                nErrors++;
                $display("[TB] FAIL scan_pair cycle %0d: got ch=%0d bcd=%0d required (2,4) or (1,7)",
                         i, disp_channel, bcd);
            end
            nChecks++;
            if ({tens, ones, wrap, bcd, disp_channel} !== expVec()) begin
                nErrors++;
                $display("[TB] FAIL scan_model cycle %0d: got %h required %h",
                         i, {tens, ones, wrap, bcd, disp_channel}, expVec());
            end
            if (disp_channel !== lastCh) begin
                if (seenChange) begin
                    nChecks++;
                    if (runLen != SCAN_DIV) begin
                        nErrors++;
                        $display("[TB] FAIL scan_hold_len: got %0d cycles required %0d", runLen, SCAN_DIV);
                    end
                end
                seenChange = 1'b1;
                runLen = 1;
            end else begin
                runLen++;
            end
            lastCh = disp_channel;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            clkCycle();
            nChecks++;
            if ({tens, ones, wrap, bcd, disp_channel} !== expVec()) begin
                nErrors++;
                $display("[TB] FAIL random cycle %0d: got %h required %h",
                         i, {tens, ones, wrap, bcd, disp_channel}, expVec());
            end
            nChecks++;
            if (tens > 4'd9 || ones > 4'd9 || bcd > 4'd9 || disp_channel == 2'd0 || disp_channel == 2'd3) begin
                nErrors++;
                $display("[TB] FAIL random_range cycle %0d: got t=%0d o=%0d b=%0d ch=%0d required digits<=9 ch in 1..2",
                         i, tens, ones, bcd, disp_channel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_up();
        test_carry_borrow();
        test_load_clamp();
        test_hold();
        test_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
